dmem_lat: RTL and testbench

- Parametrised data memory for the RISC-V core; the successor to the flat single-cycle memory.
- Uses byte addressing and performs RISC-V load/store sizing with funct3 encoding: byte/half/word, signed/unsigned loads.
- Has a configurable wait-state latency behind a req/ready handshake, so multicycle and pipelined datapaths can model a slow memory.
- Sits between the datapath's memory stage and the controller, which stalls on busy.

---
 rtl/dmem_lat.sv | 199 +++++++++++++++++++
 tb/tb_dmem_lat.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_lat.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_lat
//  Purpose  : Byte-addressed RISC-V data memory with RISC-V load/store
//             sizing (funct3) and a fixed wait-state latency behind a
//             req/busy/ready handshake.
//  Options  : DMEM_MISALIGN_TRAP_EN - flag misaligned or illegal-size
//             accesses on err instead of aligning down / treating as word.
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_lat #(
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 2,
   parameter int ADDR_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              We,
   input  logic [ADDR_W-1:0] A,
   input  logic [31:0]       WD,
   input  logic [2:0]        size,
   output logic [31:0]       RD,
   output logic              busy,
   output logic              ready,
   output logic              err
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   state_t             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [CNT_W-1:0]   cnt_d;
   logic               we_q;
   logic [IDX_W+1:0]   addr_q;
   logic [31:0]        wd_q;
   logic [2:0]         size_q;
   logic [31:0]        rd_q;
   logic [31:0]        rd_d;
   logic               busy_q;
   logic               ready_q;
   logic               err_q;

   logic [31:0]        mem_q [DEPTH];

   logic [IDX_W-1:0]   w_idx;
   logic [1:0]         w_lane;
   logic [31:0]        w_word;
   logic [7:0]         w_byte;
   logic [15:0]        w_half;
   logic [3:0]         w_bmask;
   logic [31:0]        w_wdata;
   logic [31:0]        w_bitmask;
   logic [31:0]        w_merged;
   logic               w_complete;
   logic               w_err;

   // High address bits are intentionally ignored so the memory wraps.
   if (ADDR_W > IDX_W + 2) begin : g_unused
      logic w_unused_addr;
      assign w_unused_addr = ^A[ADDR_W-1:IDX_W+2];
   end

   assign w_idx      = addr_q[IDX_W+1:2];
   assign w_lane     = addr_q[1:0];
   assign w_word     = mem_q[w_idx];
   assign w_complete = (state_q == ST_WAIT) && (cnt_q == '0);
   assign cnt_d      = cnt_q - CNT_W'(1);

   // Lane extraction and load sign/zero extension.
   always_comb begin
      w_byte = w_word[7:0];
      case (w_lane)
         2'd0:    w_byte = w_word[7:0];
         2'd1:    w_byte = w_word[15:8];
         2'd2:    w_byte = w_word[23:16];
         default: w_byte = w_word[31:24];
      endcase
      w_half = w_lane[1] ? w_word[31:16] : w_word[15:0];
      case (size_q)
         3'b000:  rd_d = {{24{w_byte[7]}}, w_byte};
         3'b001:  rd_d = {{16{w_half[15]}}, w_half};
         3'b100:  rd_d = {24'd0, w_byte};
         3'b101:  rd_d = {16'd0, w_half};
         default: rd_d = w_word;
      endcase
   end

   // Store lane mask and replicated store data merged into the old word.
   always_comb begin
      w_bmask = 4'b1111;
      w_wdata = wd_q;
      case (size_q[1:0])
         2'b00: begin
            w_bmask = 4'b0001 << w_lane;
            w_wdata = {4{wd_q[7:0]}};
         end
         2'b01: begin
            w_bmask = w_lane[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{wd_q[15:0]}};
         end
         default: begin
            w_bmask = 4'b1111;
            w_wdata = wd_q;
         end
      endcase
      w_bitmask = {{8{w_bmask[3]}}, {8{w_bmask[2]}}, {8{w_bmask[1]}}, {8{w_bmask[0]}}};
      w_merged  = (w_word & ~w_bitmask) | (w_wdata & w_bitmask);
   end

`ifdef DMEM_MISALIGN_TRAP_EN
   // Illegal size codes and misaligned half/word accesses raise err.
   always_comb begin
      w_err = 1'b0;
      if (we_q) begin
         if (size_q[1:0] == 2'b11)
            w_err = 1'b1;
      end else begin
         if ((size_q == 3'b011) || (size_q == 3'b110) || (size_q == 3'b111))
            w_err = 1'b1;
      end
      if ((size_q[1:0] == 2'b01) && w_lane[0])
         w_err = 1'b1;
      if ((size_q[1:0] == 2'b10) && (w_lane != 2'b00))
         w_err = 1'b1;
   end
`else
   assign w_err = 1'b0;
`endif

   // Storage array: cleared on reset, written only by a legal store at completion.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++)
            mem_q[i] <= '0;
      end else if (w_complete && we_q && !w_err) begin
         mem_q[w_idx] <= w_merged;
      end
   end

   // Handshake FSM: capture in IDLE, count down in WAIT, complete at zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wd_q    <= '0;
         size_q  <= '0;
         rd_q    <= '0;
         busy_q  <= 1'b0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (req) begin
                  we_q    <= We;
                  addr_q  <= A[IDX_W+1:0];
                  wd_q    <= WD;
                  size_q  <= size;
                  cnt_q   <= CNT_LOAD;
                  busy_q  <= 1'b1;
                  state_q <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (cnt_q == '0) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
                  ready_q <= 1'b1;
                  err_q   <= w_err;
                  if (!we_q && !w_err)
                     rd_q <= rd_d;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign RD    = rd_q;
   assign busy  = busy_q;
   assign ready = ready_q;
   assign err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_lat.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_lat
//  Purpose  : Directed self-checking bench for dmem_lat (LATENCY=2).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_lat;

   logic        clk = 1'b0;
   logic        rst;
   logic        req;
   logic        We;
   logic [31:0] A;
   logic [31:0] WD;
   logic [2:0]  size;
   logic [31:0] RD;
   logic        busy;
   logic        ready;
   logic        err;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   dmem_lat #(.DEPTH(1024), .LATENCY(2), .ADDR_W(32)) dut (
      .clk(clk), .rst(rst), .req(req), .We(We), .A(A), .WD(WD),
      .size(size), .RD(RD), .busy(busy), .ready(ready), .err(err)
   );

   // Drives one request from a negedge and returns at the negedge of the ready cycle.
   task automatic do_access(input logic we_v, input logic [31:0] a_v, input logic [31:0] wd_v,
                            input logic [2:0] sz_v, output int lat, output logic busy_ok);
      req = 1'b1; We = we_v; A = a_v; WD = wd_v; size = sz_v;
      @(posedge clk);
      @(negedge clk);
      req = 1'b0;
      lat = 0;
      busy_ok = 1'b1;
      while (ready !== 1'b1 && lat < 20) begin
         if (busy !== 1'b1) busy_ok = 1'b0;
         @(negedge clk);
         lat++;
      end
      if (ready !== 1'b1) begin
         n_vec++; n_err++;
         $display("FAIL timeout: no ready within %0d cycles (A=%h)", lat, a_v);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; req = 1'b0; We = 1'b0; A = '0; WD = '0; size = 3'b010;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_vec++; if (RD !== 32'h0)  begin n_err++; $display("FAIL reset_rd: got %h want %h", RD, 32'h0); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_vec++; if (ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", ready); end
      n_vec++; if (err !== 1'b0)  begin n_err++; $display("FAIL reset_err: got %b want 0", err); end
   endtask

   task automatic test_basic();
      int lat; logic bok;
      do_access(1'b1, 32'd100, 32'h00000011, 3'b010, lat, bok);
      n_vec++; if (lat !== 2) begin n_err++; $display("FAIL sw_latency: got %0d want 2", lat); end
      n_vec++; if (bok !== 1'b1) begin n_err++; $display("FAIL sw_busy_wait: got %b want 1", bok); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL busy_in_ready: got %b want 0", busy); end
      n_vec++; if (RD !== 32'h0) begin n_err++; $display("FAIL rd_after_store: got %h want %h", RD, 32'h0); end
      do_access(1'b0, 32'd100, 32'h0, 3'b010, lat, bok);
      n_vec++; if (RD !== 32'h00000011) begin n_err++; $display("FAIL lw_100: got %h want %h", RD, 32'h00000011); end
      n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL lw_err: got %b want 0", err); end
      @(negedge clk);
      n_vec++; if (ready !== 1'b0) begin n_err++; $display("FAIL ready_one_cycle: got %b want 0", ready); end
   endtask

   task automatic test_load_sizes();
      int lat; logic bok;
      logic [31:0] addrs [5];
      logic [2:0]  szs   [5];
      logic [31:0] exps  [5];
      addrs = '{32'd8, 32'd11, 32'd11, 32'd10, 32'd10};
      szs   = '{3'b000, 3'b000, 3'b100, 3'b001, 3'b101};
      exps  = '{32'h00000001, 32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF};
      do_access(1'b1, 32'd8, 32'h80FF7F01, 3'b010, lat, bok);
      for (int i = 0; i < 5; i++) begin
         do_access(1'b0, addrs[i], 32'h0, szs[i], lat, bok);
         n_vec++;
         if (RD !== exps[i]) begin
            n_err++;
            $display("FAIL load_size[%0d] A=%0d size=%b: got %h want %h", i, addrs[i], szs[i], RD, exps[i]);
         end
      end
   endtask

   task automatic test_partial_store();
      int lat; logic bok;
      do_access(1'b1, 32'd20, 32'hAABBCCDD, 3'b010, lat, bok);
      do_access(1'b1, 32'd21, 32'h00000011, 3'b000, lat, bok);
      do_access(1'b0, 32'd20, 32'h0, 3'b010, lat, bok);
      n_vec++; if (RD !== 32'hAABB11DD) begin n_err++; $display("FAIL sb_merge: got %h want %h", RD, 32'hAABB11DD); end
      do_access(1'b1, 32'd22, 32'h00002233, 3'b001, lat, bok);
      do_access(1'b0, 32'd20, 32'h0, 3'b010, lat, bok);
      n_vec++; if (RD !== 32'h223311DD) begin n_err++; $display("FAIL sh_merge: got %h want %h", RD, 32'h223311DD); end
   endtask

   task automatic test_wrap();
      int lat; logic bok;
      do_access(1'b1, 32'd4100, 32'h00000005, 3'b010, lat, bok);
      do_access(1'b0, 32'd4, 32'h0, 3'b010, lat, bok);
      n_vec++; if (RD !== 32'h00000005) begin n_err++; $display("FAIL wrap: got %h want %h", RD, 32'h00000005); end
   endtask

   task automatic test_busy_ignore();
      int readies = 0;
      int cyc = 0;
      req = 1'b1; We = 1'b0; A = 32'd4; WD = '0; size = 3'b010;
      @(posedge clk);
      @(negedge clk);
      A = 32'd100;
      while (ready !== 1'b1 && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      req = 1'b0;
      if (ready === 1'b1) readies++;
      n_vec++; if (RD !== 32'h00000005) begin n_err++; $display("FAIL busy_ignore_rd: got %h want %h", RD, 32'h00000005); end
      repeat (6) begin
         @(negedge clk);
         if (ready === 1'b1) readies++;
      end
      n_vec++; if (readies !== 1) begin n_err++; $display("FAIL busy_ignore_readies: got %0d want 1", readies); end
   endtask

   task automatic test_reset_mid();
      int lat; logic bok;
      int readies = 0;
      req = 1'b1; We = 1'b1; A = 32'd0; WD = 32'h7; size = 3'b010;
      @(posedge clk);
      @(negedge clk);
      req = 1'b0; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
      n_vec++; if (ready !== 1'b0) begin n_err++; $display("FAIL rst_mid_ready: got %b want 0", ready); end
      repeat (4) begin
         @(negedge clk);
         if (ready === 1'b1) readies++;
      end
      n_vec++; if (readies !== 0) begin n_err++; $display("FAIL rst_mid_no_ready: got %0d want 0", readies); end
      do_access(1'b0, 32'd0, 32'h0, 3'b010, lat, bok);
      n_vec++; if (RD !== 32'h0) begin n_err++; $display("FAIL rst_mid_word0: got %h want %h", RD, 32'h0); end
      do_access(1'b0, 32'd100, 32'h0, 3'b010, lat, bok);
      n_vec++; if (RD !== 32'h0) begin n_err++; $display("FAIL rst_clears_mem: got %h want %h", RD, 32'h0); end
   endtask

   task automatic test_misalign();
      int lat; logic bok;
      logic [31:0] exp_w, exp_h, exp_i;
      logic        exp_e;
`ifdef DMEM_MISALIGN_TRAP_EN
      exp_e = 1'b1; exp_w = 32'h0; exp_h = 32'h0; exp_i = 32'h0;
`else
      exp_e = 1'b0; exp_w = 32'hDEADBEEF; exp_h = 32'hFFFFBEEF; exp_i = 32'hDEADBEEF;
`endif
      do_access(1'b1, 32'd2, 32'hDEADBEEF, 3'b010, lat, bok);
      n_vec++; if (err !== exp_e) begin n_err++; $display("FAIL misalign_sw_err: got %b want %b", err, exp_e); end
      n_vec++; if (lat !== 2) begin n_err++; $display("FAIL misalign_latency: got %0d want 2", lat); end
      do_access(1'b0, 32'd0, 32'h0, 3'b010, lat, bok);
      n_vec++; if (RD !== exp_w) begin n_err++; $display("FAIL misalign_word0: got %h want %h", RD, exp_w); end
      n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL legal_lw_err: got %b want 0", err); end
      do_access(1'b0, 32'd1, 32'h0, 3'b001, lat, bok);
      n_vec++; if (RD !== exp_h) begin n_err++; $display("FAIL misalign_lh: got %h want %h", RD, exp_h); end
      n_vec++; if (err !== exp_e) begin n_err++; $display("FAIL misalign_lh_err: got %b want %b", err, exp_e); end
      do_access(1'b0, 32'd0, 32'h0, 3'b011, lat, bok);
      n_vec++; if (RD !== exp_i) begin n_err++; $display("FAIL illegal_size_ld: got %h want %h", RD, exp_i); end
      n_vec++; if (err !== exp_e) begin n_err++; $display("FAIL illegal_size_err: got %b want %b", err, exp_e); end
      @(negedge clk);
      n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL err_pulse: got %b want 0", err); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_load_sizes();
      test_partial_store();
      test_wrap();
      test_busy_ignore();
      test_reset_mid();
      test_misalign();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
